// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: IR field layout,
// ALU opcodes, FSM states and instruction classes.
package cpu_ctrl_pkg;

    localparam int unsigned IR_W      = 32;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_IDX_W = 4;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd6;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd15;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd16;
    localparam logic [OPC_W-1:0] OP_NEG = 5'd17;
    localparam logic [OPC_W-1:0] OP_NOT = 5'd18;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_THREE_OP,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decoder: instruction class plus one-hot register selects,
// with register indices checked against the register-file size.
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic [IR_W-1:0]     ir,
    output logic [OPC_W-1:0]    opcode,
    output instr_class_e        cls,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh
);

    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic                 ra_ok;
    logic                 rb_ok;
    logic                 rc_ok;
    logic                 unused_ir_low;

    assign opcode        = ir[OPC_LSB +: OPC_W];
    assign ra            = ir[RA_LSB +: REG_IDX_W];
    assign rb            = ir[RB_LSB +: REG_IDX_W];
    assign rc            = ir[RC_LSB +: REG_IDX_W];
    assign unused_ir_low = ^ir[RC_LSB-1:0];

    // An index beyond the register file yields an all-zero one-hot.
    always_comb begin
        ra_oh = '0;
        rb_oh = '0;
        rc_oh = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            ra_oh[i] = (ra == REG_IDX_W'(i));
            rb_oh[i] = (rb == REG_IDX_W'(i));
            rc_oh[i] = (rc == REG_IDX_W'(i));
        end
    end

    assign ra_ok = |ra_oh;
    assign rb_ok = |rb_oh;
    assign rc_ok = |rc_oh;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: if (ra_ok && rb_ok && rc_ok) cls = CLS_THREE_OP;
            OP_NEG, OP_NOT:                if (ra_ok && rb_ok)          cls = CLS_UNARY;
            OP_MUL, OP_DIV:                if (ra_ok && rb_ok)          cls = CLS_MULDIV;
            default:                       cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath strobes for
// register-to-register ALU, unary and MUL/DIV instructions.
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ack,
    input  logic [IR_W-1:0]     ir,
    output logic                pc_out,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mem_read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                z_high_out,
    output logic                z_low_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic [NUM_REGS-1:0] r_in,
    output logic [OPC_W-1:0]    alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    state_e                state;
    state_e                state_next;
    instr_class_e          cls;
    logic [OPC_W-1:0]      opcode;
    logic [NUM_REGS-1:0]   ra_oh;
    logic [NUM_REGS-1:0]   rb_oh;
    logic [NUM_REGS-1:0]   rc_oh;
    logic                  illegal_set;

    instr_decode #(
        .NUM_REGS(NUM_REGS)
    ) u_decode (
        .ir     (ir),
        .opcode (opcode),
        .cls    (cls),
        .ra_oh  (ra_oh),
        .rb_oh  (rb_oh),
        .rc_oh  (rc_oh)
    );

    always_ff @(posedge clock) begin
        if (!clear) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!clear)           illegal <= 1'b0;
        else if (illegal_set) illegal <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!clear)    retired <= '0;
        else if (done) retired <= retired + CNT_W'(1);
    end

    // Moore decode of strobes from the current state and the IR fields.
    always_comb begin
        state_next  = state;
        pc_out      = 1'b0;
        inc_pc      = 1'b0;
        mar_in      = 1'b0;
        mem_read    = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        z_high_out  = 1'b0;
        z_low_out   = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        r_out       = '0;
        r_in        = '0;
        done        = 1'b0;
        illegal_set = 1'b0;

        case (state)
            ST_IDLE: if (run) state_next = ST_T0;
            ST_T0: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                state_next = ST_T1;
            end
            ST_T1: begin
                mem_read = 1'b1;
                if (mem_ack) begin
                    mdr_in     = 1'b1;
                    state_next = ST_T2;
                end
            end
            ST_T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = ST_T3;
            end
            ST_T3: begin
                state_next = ST_T4;
                case (cls)
                    CLS_THREE_OP: begin r_out = rb_oh; y_in = 1'b1; end
                    CLS_UNARY:    begin r_out = rb_oh; z_in = 1'b1; end
                    CLS_MULDIV:   begin r_out = ra_oh; y_in = 1'b1; end
                    default: begin
                        illegal_set = 1'b1;
                        state_next  = ST_HALT;
                    end
                endcase
            end
            ST_T4: begin
                state_next = ST_T5;
                case (cls)
                    CLS_UNARY: begin
                        z_low_out = 1'b1;
                        r_in      = ra_oh;
                        done      = 1'b1;
                    end
                    CLS_THREE_OP: begin r_out = rc_oh; z_in = 1'b1; end
                    default:      begin r_out = rb_oh; z_in = 1'b1; end
                endcase
            end
            ST_T5: begin
                z_low_out = 1'b1;
                if (cls == CLS_MULDIV) begin
                    lo_in      = 1'b1;
                    state_next = ST_T6;
                end else begin
                    r_in = ra_oh;
                    done = 1'b1;
                end
            end
            ST_T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
                done       = 1'b1;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase

        // Completion chains straight into the next fetch while run is held.
        if (done) state_next = run ? ST_T0 : ST_IDLE;

        alu_op = z_in ? opcode : '0;
        busy   = (state != ST_IDLE) && (state != ST_HALT);
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench: two sequencers (16 regs / 8 regs with a 4-bit counter) see
// the same stimulus; per-cycle expectations come from a cycle-indexed model.
module tb_ctrl_sequencer;

    typedef struct packed {
        logic [12:0] strb;
        logic [15:0] r_out;
        logic [15:0] r_in;
        logic [4:0]  alu_op;
        logic        busy;
        logic        done;
        logic        illegal;
        logic [15:0] retired;
    } obs_t;

    localparam logic [12:0] PC   = 13'h1000;
    localparam logic [12:0] INC  = 13'h0800;
    localparam logic [12:0] MAR  = 13'h0400;
    localparam logic [12:0] MRD  = 13'h0200;
    localparam logic [12:0] MDRI = 13'h0100;
    localparam logic [12:0] MDRO = 13'h0080;
    localparam logic [12:0] IRI  = 13'h0040;
    localparam logic [12:0] YI   = 13'h0020;
    localparam logic [12:0] ZI   = 13'h0010;
    localparam logic [12:0] ZH   = 13'h0008;
    localparam logic [12:0] ZL   = 13'h0004;
    localparam logic [12:0] HI   = 13'h0002;
    localparam logic [12:0] LO   = 13'h0001;
    localparam int NR_B = 8;

    logic        clock;
    logic        clear;
    logic        run;
    logic        mem_ack;
    logic [31:0] ir;

    wire [12:0] sa, sb;
    wire [15:0] ro_a, ri_a, ret_a;
    wire [7:0]  ro_b, ri_b;
    wire [3:0]  ret_b;
    wire [4:0]  op_a, op_b;
    wire        busy_a, done_a, ill_a, busy_b, done_b, ill_b;

    int n_checks = 0;
    int n_fail   = 0;
    obs_t qa[$];
    obs_t qb[$];
    int unsigned cnt_a, cnt_b;
    bit halt_a, halt_b, at_t0;
    int legal_ops [8] = '{3, 4, 5, 6, 15, 16, 17, 18};

    ctrl_sequencer #(.NUM_REGS(16), .CNT_W(16)) dut_a (
        .clock(clock), .clear(clear), .run(run), .mem_ack(mem_ack), .ir(ir),
        .pc_out(sa[12]), .inc_pc(sa[11]), .mar_in(sa[10]), .mem_read(sa[9]),
        .mdr_in(sa[8]), .mdr_out(sa[7]), .ir_in(sa[6]), .y_in(sa[5]), .z_in(sa[4]),
        .z_high_out(sa[3]), .z_low_out(sa[2]), .hi_in(sa[1]), .lo_in(sa[0]),
        .r_out(ro_a), .r_in(ri_a), .alu_op(op_a), .busy(busy_a), .done(done_a),
        .illegal(ill_a), .retired(ret_a)
    );

    ctrl_sequencer #(.NUM_REGS(NR_B), .CNT_W(4)) dut_b (
        .clock(clock), .clear(clear), .run(run), .mem_ack(mem_ack), .ir(ir),
        .pc_out(sb[12]), .inc_pc(sb[11]), .mar_in(sb[10]), .mem_read(sb[9]),
        .mdr_in(sb[8]), .mdr_out(sb[7]), .ir_in(sb[6]), .y_in(sb[5]), .z_in(sb[4]),
        .z_high_out(sb[3]), .z_low_out(sb[2]), .hi_in(sb[1]), .lo_in(sb[0]),
        .r_out(ro_b), .r_in(ri_b), .alu_op(op_b), .busy(busy_b), .done(done_b),
        .illegal(ill_b), .retired(ret_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got strb=%h r_out=%h r_in=%h alu_op=%0d busy=%b done=%b illegal=%b retired=%0d; want strb=%h r_out=%h r_in=%h alu_op=%0d busy=%b done=%b illegal=%b retired=%0d",
                     name, $time, act.strb, act.r_out, act.r_in, act.alu_op, act.busy, act.done,
                     act.illegal, act.retired, exp.strb, exp.r_out, exp.r_in, exp.alu_op,
                     exp.busy, exp.done, exp.illegal, exp.retired);
        end
    endtask

    // Monitor: one expected observation per DUT per cycle, sampled mid-cycle.
    always @(negedge clock) begin
        obs_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("dut16", {sa, ro_a, ri_a, op_a, busy_a, done_a, ill_a, ret_a}, e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("dut8", {sb, 8'h00, ro_b, 8'h00, ri_b, op_b, busy_b, done_b, ill_b, 12'h000, ret_b}, e);
        end
    end

    function automatic obs_t mk(input logic [12:0] s, input logic [15:0] ro, input logic [15:0] ri,
                                input logic [4:0] op, input logic bz, input logic dn,
                                input logic il, input logic [15:0] rt);
        obs_t o;
        o.strb = s; o.r_out = ro; o.r_in = ri; o.alu_op = op;
        o.busy = bz; o.done = dn; o.illegal = il; o.retired = rt;
        return o;
    endfunction

    function automatic logic [15:0] oh(input int n);
        logic [15:0] one;
        one = 16'h0001;
        return one << n;
    endfunction

    function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0000};
    endfunction

    // 0 = three-operand, 1 = unary, 2 = mul/div, 3 = illegal
    function automatic int classify(input logic [31:0] i, input int nr);
        int op, ra, rb, rc, cls;
        op = int'(i[31:27]); ra = int'(i[26:23]); rb = int'(i[22:19]); rc = int'(i[18:15]);
        if (op >= 3 && op <= 6)        cls = 0;
        else if (op == 17 || op == 18) cls = 1;
        else if (op == 15 || op == 16) cls = 2;
        else                           return 3;
        if (ra >= nr || rb >= nr || (cls == 0 && rc >= nr)) return 3;
        return cls;
    endfunction

    function automatic int n_cycles(input logic [31:0] i, input int waits, input int nr);
        case (classify(i, nr))
            0:       return waits + 6;
            1:       return waits + 5;
            2:       return waits + 7;
            default: return waits + 4;
        endcase
    endfunction

    function automatic obs_t exec_step(input logic [31:0] i, input int cls, input int s, input logic [15:0] rt);
        int ra, rb, rc;
        logic [4:0] op;
        op = i[31:27]; ra = int'(i[26:23]); rb = int'(i[22:19]); rc = int'(i[18:15]);
        if (cls == 0) begin
            if (s == 0) return mk(YI, oh(rb), 16'h0, 5'd0, 1, 0, 0, rt);
            if (s == 1) return mk(ZI, oh(rc), 16'h0, op, 1, 0, 0, rt);
            return mk(ZL, 16'h0, oh(ra), 5'd0, 1, 1, 0, rt);
        end
        if (cls == 1) begin
            if (s == 0) return mk(ZI, oh(rb), 16'h0, op, 1, 0, 0, rt);
            return mk(ZL, 16'h0, oh(ra), 5'd0, 1, 1, 0, rt);
        end
        if (s == 0) return mk(YI, oh(ra), 16'h0, 5'd0, 1, 0, 0, rt);
        if (s == 1) return mk(ZI, oh(rb), 16'h0, op, 1, 0, 0, rt);
        if (s == 2) return mk(ZL | LO, 16'h0, 16'h0, 5'd0, 1, 0, 0, rt);
        return mk(ZH | HI, 16'h0, 16'h0, 5'd0, 1, 1, 0, rt);
    endfunction

    // Expected observation k cycles after T0 of instruction i with `waits` stalled T1 cycles.
    function automatic obs_t at_cycle(input logic [31:0] i, input int waits, input int nr,
                                      input bit halted, input logic [15:0] rt, input int k);
        int f, cls;
        f = waits + 3;
        cls = classify(i, nr);
        if (halted)         return mk(13'h0, 16'h0, 16'h0, 5'd0, 0, 0, 1, rt);
        if (k == 0)         return mk(PC | INC | MAR, 16'h0, 16'h0, 5'd0, 1, 0, 0, rt);
        if (k <= waits)     return mk(MRD, 16'h0, 16'h0, 5'd0, 1, 0, 0, rt);
        if (k == waits + 1) return mk(MRD | MDRI, 16'h0, 16'h0, 5'd0, 1, 0, 0, rt);
        if (k == waits + 2) return mk(MDRO | IRI, 16'h0, 16'h0, 5'd0, 1, 0, 0, rt);
        if (cls == 3) begin
            if (k == f) return mk(13'h0, 16'h0, 16'h0, 5'd0, 1, 0, 0, rt);
            return mk(13'h0, 16'h0, 16'h0, 5'd0, 0, 0, 1, rt);
        end
        return exec_step(i, cls, k - f, rt);
    endfunction

    function automatic obs_t state_vec(input bit halted, input logic [15:0] rt);
        return mk(13'h0, 16'h0, 16'h0, 5'd0, 0, 0, halted, rt);
    endfunction

    task automatic drive(input logic c, input logic r, input logic ack, input logic [31:0] i,
                         input obs_t ea, input obs_t eb);
        @(posedge clock);
        #1;
        clear = c; run = r; mem_ack = ack; ir = i;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic reset_model();
        cnt_a = 0; cnt_b = 0; halt_a = 0; halt_b = 0; at_t0 = 0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int j = 0; j < n; j++)
            drive(1'b1, r, 1'($urandom), $urandom,
                  state_vec(halt_a, 16'(cnt_a)), state_vec(halt_b, 16'(cnt_b % 16)));
    endtask

    task automatic do_reset();
        obs_t ea, eb;
        ea = at_t0 ? at_cycle(32'h0, 0, 16, 0, 16'(cnt_a), 0) : state_vec(halt_a, 16'(cnt_a));
        eb = (at_t0 && !halt_b) ? at_cycle(32'h0, 0, NR_B, 0, 16'(cnt_b % 16), 0)
                                : state_vec(halt_b, 16'(cnt_b % 16));
        drive(1'b0, 1'($urandom), 1'($urandom), $urandom, ea, eb);
        reset_model();
    endtask

    // One instruction from T0; `cut` >= 0 pulls clear low in that cycle of the instruction.
    task automatic do_instr(input logic [31:0] i, input int waits, input bit run_after, input int cut);
        int n;
        if (!at_t0)
            drive(1'b1, 1'b1, 1'($urandom), $urandom,
                  state_vec(halt_a, 16'(cnt_a)), state_vec(halt_b, 16'(cnt_b % 16)));
        n = n_cycles(i, waits, 16);
        for (int k = 0; k < n; k++) begin
            logic c, r, ack;
            logic [31:0] iv;
            iv  = (k < waits + 3) ? $urandom : i;
            ack = (k >= 1 && k <= waits + 1) ? logic'(k == waits + 1) : 1'($urandom);
            r   = (k == n - 1) ? run_after : 1'($urandom);
            c   = (k != cut);
            drive(c, r, ack, iv,
                  at_cycle(i, waits, 16, halt_a, 16'(cnt_a), k),
                  at_cycle(i, waits, NR_B, halt_b, 16'(cnt_b % 16), k));
            if (!c) break;
        end
        if (cut >= 0 && cut < n) begin
            reset_model();
        end else begin
            if (classify(i, 16) == 3) halt_a = 1;
            else                      cnt_a++;
            if (!halt_b) begin
                if (classify(i, NR_B) == 3) halt_b = 1;
                else                        cnt_b++;
            end
            at_t0 = run_after && !halt_a;
        end
    endtask

    function automatic int rnd_reg();
        return ($urandom % 16 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [31:0] ri;
        int op, w, cut;
        clear = 1'b0; run = 1'b0; mem_ack = 1'b0; ir = 32'h0;
        reset_model();
        repeat (2) @(posedge clock);
        idle(3, 1'b0);

        do_instr(32'h8B38_0000, 0, 1, -1);
        do_instr(32'h191A_0000, 0, 1, -1);
        do_instr(32'h7988_0000, 0, 0, -1);
        idle(2, 1'b0);
        do_instr(32'h8B38_0000, 3, 0, -1);
        do_instr(enc(17, 9, 1, 0), 0, 1, -1);
        do_instr(32'h7988_0000, 0, 1, 5);
        do_instr(32'h8B38_0000, 0, 1, -1);
        do_instr(32'hF800_0000, 1, 1, -1);
        idle(3, 1'b1);
        do_reset();
        for (int j = 0; j < 18; j++) do_instr(32'h8B38_0000, int'($urandom_range(0, 2)), 1, -1);
        do_reset();

        for (int it = 0; it < 220; it++) begin
            if (halt_a) begin
                idle(2, 1'b1);
                do_reset();
            end else if (it % 40 == 39) begin
                do_reset();
            end
            if (!at_t0 && $urandom % 4 == 0) idle(int'($urandom_range(1, 3)), 1'b0);
            op  = ($urandom % 16 == 0) ? int'($urandom % 32) : legal_ops[$urandom % 8];
            ri  = enc(op, rnd_reg(), rnd_reg(), rnd_reg()) | {17'h0, 15'($urandom)};
            w   = int'($urandom_range(0, 3));
            cut = ($urandom % 12 == 0) ? int'($urandom_range(0, n_cycles(ri, w, 16) - 1)) : -1;
            do_instr(ri, w, ($urandom % 4) != 0, cut);
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Hardwired control sequencer for the RISC datapath. It replaces per-instruction, hand-driven T-state strobes with a state machine that fetches, decodes and executes register-to-register ALU instructions. It sits beside the `CPU` datapath, drives its in/out/enable strobes, and reads back the IR contents. It is parametrised in register-file size, adds a memory-ready handshake and multi-cycle MUL/DIV sequences, and counts retired instructions.

## Interface
- `NUM_REGS`, 16, number of general registers; width of the one-hot `r_out`/`r_in` buses (2..16).
- `CNT_W`, 16, width of the retired-instruction counter.
- `clock` in 1: sole clock; all state changes on the rising edge.
- `clear` in 1: synchronous, active-low reset; sampled on the rising edge of `clock`.
- `run` in 1: level enable; start and continue fetching.
- `mem_ack` in 1: memory read data valid on `mDataIn` this cycle.
- `ir` in 32: IR register contents; stable from T3 onward.
- `pc_out`, `inc_pc`, `mar_in`, `mem_read`, `mdr_in`, `mdr_out`, `ir_in` out 1: fetch strobes.
- `y_in`, `z_in`, `z_high_out`, `z_low_out`, `hi_in`, `lo_in` out 1: execute strobes.
- `r_out` out `NUM_REGS`: one-hot register-to-bus select.
- `r_in` out `NUM_REGS`: one-hot bus-to-register load.
- `alu_op` out 5: opcode presented to the ALU, valid while `z_in`=1, else 0.
- `busy` out 1: high in any state except IDLE and HALT.
- `done` out 1: one-cycle pulse in the last execute cycle of each instruction.
- `illegal` out 1: sticky; set on an undecodable instruction.
- `retired` out `CNT_W`: count of completed instructions; wraps modulo 2^`CNT_W`.

## Operation
- IR fields: opcode=`ir[31:27]`, ra=`ir[26:23]`, rb=`ir[22:19]`, rc=`ir[18:15]`.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- IDLE → T0 when `run`=1.
- T0: `pc_out`, `mar_in`, `inc_pc`.
- T1: `mem_read`=1 every cycle. The state holds until `mem_ack`=1. `mdr_in`=1 only in the cycle with `mem_ack`=1, then the state advances to T2.
- T2: `mdr_out`, `ir_in`.
- Three-operand ops (ADD 3, SUB 4, AND 5, OR 6):
  - T3: `r_out[rb]`, `y_in`.
  - T4: `r_out[rc]`, `z_in`.
  - T5: `z_low_out`, `r_in[ra]`, `done`.
- Unary ops (NEG 17, NOT 18):
  - T3: `r_out[rb]`, `z_in`.
  - T4: `z_low_out`, `r_in[ra]`, `done`.
- MUL 15, DIV 16:
  - T3: `r_out[ra]`, `y_in`.
  - T4: `r_out[rb]`, `z_in`.
  - T5: `z_low_out`, `lo_in`.
  - T6: `z_high_out`, `hi_in`, `done`.
- After the `done` cycle: next state is T0 if `run`=1, else IDLE. `retired` increments on the `done` edge.
- Illegal instruction: any other opcode, or any used register index ≥ `NUM_REGS`.
  - Detected in T3. That T3 asserts no execute strobes.
  - `illegal` sets; next state is HALT.
  - HALT is exited only by `clear`.
- `run` deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- Outputs are Moore-decoded from the state and the `ir` fields. At most one `r_out` bit is asserted, and at most one bus driver is active per cycle.

## Timing
- Reset (`clear`=0 at a rising edge), including mid-instruction:
  - FSM goes to IDLE.
  - All strobes, `r_out`, `r_in`, `alu_op`, `busy`, `done`, `illegal` = 0.
  - `retired` = 0.
- Latency from T0, with `mem_ack` high on the first T1 cycle:
  - Unary: 5 cycles.
  - Three-operand: 6 cycles.
  - MUL/DIV: 7 cycles.
  - Each extra T1 wait cycle adds 1.
- Back-to-back: T0 of the next instruction directly follows the `done` cycle. There is no idle bubble while `run`=1.
- `mem_ack` is ignored outside T1.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - opcode localparams;
  - state enum;
  - IR field bit positions.
- One natural sub-module, `instr_decode`: combinational. Maps `ir` to class (THREE_OP / UNARY / MULDIV / ILLEGAL) plus the ra/rb/rc one-hots; checks register indices against `NUM_REGS`.

## Test plan
- NEG R6,R7: `ir`=0x8B38_0000, `mem_ack`=1.
  - T3: `r_out`=0x0080, `z_in`=1, `alu_op`=17.
  - T4: `z_low_out`=1, `r_in`=0x0040, `done`=1.
  - `retired`=1.
- ADD R2,R3,R4: `ir`=0x191A_0000.
  - T3: `r_out`=0x0008, `y_in`.
  - T4: `r_out`=0x0010, `z_in`, `alu_op`=3.
  - T5: `r_in`=0x0004.
- MUL R3,R1: `ir`=0x7988_0000. Responses at T3..T6:
  - `r_out`=0x0008 with `y_in`;
  - `r_out`=0x0002 with `z_in`;
  - `lo_in`;
  - `hi_in`.
  - 7 cycles total.
- Memory wait: `mem_ack` low for 3 cycles in T1.
  - `mem_read` is high for 4 cycles.
  - `mdr_in` pulses only on the 4th.
  - NEG completes in 8 cycles.
- Illegal: `ir`=0xF800_0000 → `illegal`=1 after T3, HALT, `busy`=0. Separately, `NUM_REGS`=8 with NEG R9,R1 → `illegal`.
- Reset mid-instruction: `clear`=0 during MUL T5.
  - Next edge: all outputs 0, `retired`=0.
  - With `run`=1 held, the FSM restarts at T0 after `clear` returns to 1.
